// File: rtl/wb_burst_mem_slave.sv
// wb_burst_mem_slave: Wishbone slave with classic and incrementing/wrapping burst access to a 2^MEM_AW x 32 synchronous RAM
// Ports:
//   wb_clk_i, wb_rst_i            clock, asynchronous active-high reset
//   wb_cyc_i, wb_stb_i, wb_we_i   cycle, strobe, write enable
//   wb_adr_i                      byte address (bits [1:0] ignored)
//   wb_sel_i, wb_dat_i            byte lanes and write data
//   wb_cti_i, wb_bte_i            cycle type and burst type
//   wb_ack_o, wb_err_o, wb_rty_o  termination signals (rty tied low)
//   wb_dat_o                      read data, zero outside ack cycles
// Build option: define WBMEM_RANGE_ERR_EN to terminate accesses outside the BASE_ADDR window with wb_err_o.
module wb_burst_mem_slave #(
    parameter int          MEM_AW    = 10,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [31:0] wb_adr_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [31:0] wb_dat_i,
    input  logic [2:0]  wb_cti_i,
    input  logic [1:0]  wb_bte_i,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        wb_rty_o,
    output logic [31:0] wb_dat_o
);
    typedef enum logic [1:0] {IDLE, CLASSIC, BURST, GAP} state_t;
    state_t            state_q, state_d;
    logic [MEM_AW-1:0] addr_q, addr_d, addr_nxt, wrap_mask;
    logic              err_q, err_d, oor, start, beat, wr_en, unused_ok;
    logic [31:0]       rdata_q;
    logic [31:0]       mem [0:(1<<MEM_AW)-1];

    assign start = wb_cyc_i & wb_stb_i;
`ifdef WBMEM_RANGE_ERR_EN
    assign oor = (wb_adr_i >> (MEM_AW + 2)) != (BASE_ADDR >> (MEM_AW + 2));
`else
    assign oor = 1'b0;
`endif
    assign unused_ok = ^{wb_adr_i[1:0], wb_adr_i[31:MEM_AW+2], BASE_ADDR};
    assign wb_rty_o  = 1'b0;

    // Wrap bursts only count within the low log2(N) bits; linear uses the whole address.
    assign wrap_mask = (wb_bte_i == 2'b00) ? '1 : MEM_AW'((32'd4 << (wb_bte_i - 2'd1)) - 32'd1);
    assign addr_nxt  = (addr_q & ~wrap_mask) | ((addr_q + MEM_AW'(1)) & wrap_mask);

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start ? ((wb_cti_i == 3'b010) ? BURST : CLASSIC) : IDLE;
            CLASSIC: state_d = !wb_cyc_i ? IDLE : wb_stb_i ? GAP : CLASSIC;
            BURST:   state_d = !wb_cyc_i ? IDLE : !wb_stb_i ? BURST :
                               (wb_cti_i == 3'b010 && !err_q) ? BURST : GAP;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        beat     = (state_q == CLASSIC || state_q == BURST) && start;
        wb_ack_o = beat & ~err_q;
        wb_err_o = beat & err_q;
        wb_dat_o = wb_ack_o ? rdata_q : 32'h0;
        wr_en    = wb_ack_o & wb_we_i;
    end

    // The RAM is read at the next-cycle address so data is ready on every burst beat without bubbles.
    always_comb begin
        addr_d = (state_q == IDLE && start) ? wb_adr_i[MEM_AW+1:2] :
                 (state_q == BURST && wb_ack_o) ? addr_nxt : addr_q;
        err_d  = (state_q == IDLE && start) ? oor : err_q;
    end

    always_ff @(posedge wb_clk_i) begin
        rdata_q <= mem[addr_d];
        for (int i = 0; i < 4; i++)
            if (wr_en && wb_sel_i[i]) mem[addr_q][8*i +: 8] <= wb_dat_i[8*i +: 8];
    end
endmodule

// File: tb/tb_wb_burst_mem_slave.sv
// tb_wb_burst_mem_slave: randomized and directed checks of wb_burst_mem_slave against a word-array reference model
module tb_wb_burst_mem_slave;
    localparam int AW = 10;
    localparam int NW = 1 << AW;

    logic        clk = 1'b0, rst = 1'b1, cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [31:0] adr = '0, dat_i = '0;
    logic [3:0]  sel = '0;
    logic [2:0]  cti = '0;
    logic [1:0]  bte = '0;
    logic        ack, err, rty;
    logic [31:0] dat_o;

    wb_burst_mem_slave #(.MEM_AW(AW), .BASE_ADDR(32'h0)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
        .wb_adr_i(adr), .wb_sel_i(sel), .wb_dat_i(dat_i), .wb_cti_i(cti), .wb_bte_i(bte),
        .wb_ack_o(ack), .wb_err_o(err), .wb_rty_o(rty), .wb_dat_o(dat_o)
    );

    always #5 clk = ~clk;

    logic [31:0] mdl [NW];
    bit          known [NW];
    bit          exp_ack, exp_err, exp_dv;
    logic [31:0] exp_dat;
    int          checks = 0, failures = 0, ncap = 0, ecnt = 0;
    logic [31:0] cap [64];

    always @(negedge clk) begin
        checks++;
        if (ack !== exp_ack || err !== exp_err || rty !== 1'b0 || (exp_dv && dat_o !== exp_dat)) begin
            failures++;
            $display("FAIL bus t=%0t ack=%b want=%b err=%b want=%b rty=%b dat=%h want=%h",
                     $time, ack, exp_ack, err, exp_err, rty, dat_o, exp_dv ? exp_dat : dat_o);
        end
        if (ack && ncap < 64) begin
            cap[ncap] = dat_o;
            ncap++;
        end
        if (err) ecnt++;
    end

    task automatic lit(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h", nm, got, want);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus;
        cyc = 0; stb = 0; we = 0;
        exp_ack = 0; exp_err = 0; exp_dat = 0; exp_dv = 1;
    endtask

    function automatic int nxt(input int a, input bit [1:0] b);
        int n;
        n = (b == 2'b00) ? NW : (2 << b);
        return (a / n) * n + (a + 1) % n;
    endfunction

    function automatic bit in_range(input logic [31:0] a);
`ifdef WBMEM_RANGE_ERR_EN
        return a < 32'(4 * NW);
`else
        return a == a;
`endif
    endfunction

    task automatic mwrite(input int w, input logic [3:0] s, input logic [31:0] d);
        for (int i = 0; i < 4; i++) if (s[i]) mdl[w][8*i +: 8] = d[8*i +: 8];
        if (s == 4'hF) known[w] = 1;
    endtask

    task automatic classic(input logic [31:0] a, input bit w, input logic [3:0] s,
                           input logic [31:0] d, input logic [2:0] c);
        int wi;
        bit ok;
        wi = int'(a[AW+1:2]);
        ok = in_range(a);
        cyc = 1; stb = 1; we = w; adr = a; sel = s; dat_i = d; cti = c; bte = 2'($urandom);
        exp_ack = 0; exp_err = 0; exp_dat = 0; exp_dv = 1;
        ncap = 0; ecnt = 0;
        step;
        exp_ack = ok; exp_err = !ok;
        exp_dat = ok ? mdl[wi] : 32'h0;
        exp_dv = !ok || known[wi];
        if (ok && w) mwrite(wi, s, d);
        step;
        idle_bus;
        step;
    endtask

    // wmode: 0 read, 1 write full random, 2 random mix, 3 write full pattern A000_0000+addr
    // abort: 0 normal end, 1 drop cyc after the beats, 2 reset after the beats
    task automatic burst(input int w0, input bit [1:0] b, input int n, input int wmode,
                         input int stall_at, input bit rstall, input logic [2:0] last, input int abort);
        int a, ns;
        a = w0;
        cyc = 1; stb = 1; we = 0; adr = 32'(w0 * 4); cti = 3'b010; bte = b; sel = 0;
        exp_ack = 0; exp_err = 0; exp_dat = 0; exp_dv = 1;
        ncap = 0; ecnt = 0;
        step;
        for (int k = 0; k < n; k++) begin
            ns = (k == stall_at) ? 2 : (rstall && $urandom_range(3) == 0) ? int'($urandom_range(2, 1)) : 0;
            for (int j = 0; j < ns; j++) begin
                stb = 0; we = 1'($urandom); dat_i = $urandom; sel = 4'hF;
                exp_ack = 0; exp_dat = 0; exp_dv = 1;
                step;
            end
            stb = 1; adr = 32'(a * 4);
            cti = (k == n - 1 && abort == 0) ? last : 3'b010;
            we = (wmode == 1 || wmode == 3 || (wmode == 2 && $urandom_range(1) == 1));
            sel = (wmode == 1 || wmode == 3) ? 4'hF : 4'($urandom);
            dat_i = (wmode == 3) ? 32'hA000_0000 + 32'(a) : $urandom;
            exp_ack = 1; exp_err = 0; exp_dat = mdl[a]; exp_dv = known[a];
            if (we) mwrite(a, sel, dat_i);
            step;
            a = nxt(a, b);
        end
        if (abort == 1) begin
            cyc = 0; stb = 1; we = 1; sel = 4'hF; dat_i = $urandom;
            exp_ack = 0; exp_dat = 0; exp_dv = 1;
            step;
        end else if (abort == 2) begin
            rst = 1; stb = 1; we = 1; sel = 4'hF; dat_i = $urandom;
            exp_ack = 0; exp_dat = 0; exp_dv = 1;
            step;
            idle_bus;
            step;
            rst = 0;
        end
        idle_bus;
        step;
    endtask

    initial begin
        int          seq [8];
        int          r, w;
        logic [31:0] a, hi;
        logic [2:0]  c;
        seq = '{'h15, 'h16, 'h17, 'h10, 'h11, 'h12, 'h13, 'h14};
        idle_bus;
        for (int i = 0; i < NW; i++) known[i] = 0;
        step;
        step;
        rst = 0;
        step;
        burst(0, 2'b00, NW, 1, -1, 0, 3'b111, 0);

        classic(32'h10, 1, 4'hF, 32'hDEADBEEF, 3'b000);
        classic(32'h10, 0, 4'h0, 32'h0, 3'b000);
        lit("req028_data", cap[0], 32'hDEADBEEF);
        lit("req028_acks", 32'(ncap), 32'd1);

        classic(32'h20, 1, 4'hF, 32'h11223344, 3'b000);
        classic(32'h20, 1, 4'b0100, 32'h00AB0000, 3'b111);
        classic(32'h20, 0, 4'h0, 32'h0, 3'b000);
        lit("req031_merge", cap[0], 32'h11AB3344);

        burst('h10, 2'b00, 8, 3, -1, 0, 3'b111, 0);
        burst('h10, 2'b00, 8, 0, -1, 0, 3'b111, 0);
        lit("req029_beats", 32'(ncap), 32'd8);
        for (int k = 0; k < 8; k++) lit("req029_word", cap[k], 32'hA000_0010 + 32'(k));

        burst('h15, 2'b10, 8, 0, -1, 0, 3'b111, 0);
        for (int k = 0; k < 8; k++) lit("req030_wrap8", cap[k], 32'hA000_0000 + 32'(seq[k]));

        burst('h10, 2'b00, 8, 0, 3, 0, 3'b111, 0);
        lit("req032_beats", 32'(ncap), 32'd8);
        lit("req032_beat4", cap[3], 32'hA000_0013);
        lit("req032_beat5", cap[4], 32'hA000_0014);

        burst(NW - 2, 2'b00, 4, 0, -1, 0, 3'b000, 0);
        burst('h12, 2'b01, 6, 0, -1, 0, 3'b111, 2);
        classic(32'h48, 0, 4'h0, 32'h0, 3'b000);
        lit("reset_keeps_ram", cap[0], 32'hA000_0012);

        classic(32'h0, 1, 4'hF, 32'h0BADF00D, 3'b000);
        classic(32'h1000, 0, 4'h0, 32'h0, 3'b000);
`ifdef WBMEM_RANGE_ERR_EN
        lit("req033_acks", 32'(ncap), 32'd0);
        lit("req033_errs", 32'(ecnt), 32'd1);
`else
        lit("req033_alias", cap[0], 32'h0BADF00D);
        lit("req033_errs", 32'(ecnt), 32'd0);
`endif

        repeat (150) begin
            r = int'($urandom_range(7));
            w = int'($urandom_range(NW - 1));
`ifdef WBMEM_RANGE_ERR_EN
            hi = 32'h0;
`else
            hi = $urandom >> (AW + 2);
`endif
            if (r < 3) begin
                c = 3'($urandom);
                if (c == 3'b010) c = 3'b000;
                a = (hi << (AW + 2)) | 32'(w << 2) | 32'($urandom_range(3));
                classic(a, 1'($urandom), 4'($urandom), $urandom, c);
            end else begin
                burst(w, 2'($urandom), int'($urandom_range(20, 1)), 2, -1, 1,
                      $urandom_range(1) == 1 ? 3'b111 : 3'b000, r == 6 ? 1 : r == 7 ? 2 : 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/wb_burst_mem_slave.md
WB_BURST_MEM_SLAVE -- requirements
Module: wb_burst_mem_slave

Interface
REQ-001 Parameter MEM_AW, default 10, word-address width of the internal RAM (2^MEM_AW 32-bit words).
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000, byte base address of the RAM window; aligned to the window size.
REQ-003 wb_clk_i  in  1  sole clock; all state on its rising edge.
REQ-004 wb_rst_i  in  1  asynchronous, active-high reset.
REQ-005 wb_cyc_i, wb_stb_i, wb_we_i  in  1 each  Wishbone cycle, strobe and write enable.
REQ-006 wb_adr_i  in  32  byte address; bits [1:0] ignored.
REQ-007 wb_sel_i  in  4  byte lanes; wb_dat_i  in  32  write data.
REQ-008 wb_cti_i  in  3  cycle type: 000 classic, 010 incrementing burst, 111 end of burst; any other value is treated as classic.
REQ-009 wb_bte_i  in  2  burst type: 00 linear, 01 wrap-4, 10 wrap-8, 11 wrap-16.
REQ-010 wb_ack_o, wb_err_o, wb_rty_o  out  1 each; wb_dat_o  out  32  read data.

Function
REQ-011 FSM states: IDLE, CLASSIC, BURST, GAP.
REQ-012 IDLE: on wb_cyc_i & wb_stb_i, latch the word address and go to CLASSIC if wb_cti_i is not 010, else BURST; issue the synchronous RAM read in the same cycle.
REQ-013 CLASSIC: assert wb_ack_o for exactly one cycle with wb_dat_o valid; perform the write, if any, in that cycle; then go to GAP.
REQ-014 GAP: ack low for one cycle; then IDLE. Consecutive classic accesses therefore ack no more often than every third cycle.
REQ-015 BURST: wb_ack_o = wb_stb_i & wb_cyc_i; on each acked beat, advance the internal word address per wb_bte_i and read the next word, so wb_dat_o is valid one beat per cycle with no bubbles.
REQ-016 Address advance rule: linear adds 1 modulo 2^MEM_AW; wrap-N adds 1 to the low log2(N) bits only and keeps the upper bits.
REQ-017 Burst ends when a beat is acked while wb_cti_i = 111, or when wb_cti_i changes to a value other than 010 or 111: one final ack, then GAP.
REQ-018 Mid-burst wb_stb_i low with wb_cyc_i high: ack low, address frozen, wb_dat_o held; the burst resumes when wb_stb_i returns.
REQ-019 wb_cyc_i low in any state other than IDLE: go to IDLE the next cycle with no ack and no write.
REQ-020 Write: on each acked beat with wb_we_i high, write only the lanes whose wb_sel_i bit is set. A read in the same beat returns the pre-write data.
REQ-021 Read data is zero outside ack cycles.
REQ-022 wb_rty_o is constant 0.
REQ-023 wb_ack_o and wb_err_o are never asserted together.

Reset
REQ-024 wb_rst_i asynchronously forces IDLE, wb_ack_o = 0, wb_err_o = 0, wb_dat_o = 0 and the address register to 0. RAM contents are not cleared.
REQ-025 Reset asserted mid-burst aborts the burst: no further ack until a new wb_stb_i arrives after reset is released.

Configuration
REQ-026 Macro WBMEM_RANGE_ERR_EN. When defined, an access whose wb_adr_i lies outside [BASE_ADDR, BASE_ADDR + 4*2^MEM_AW) is terminated with a one-cycle wb_err_o in place of wb_ack_o, with no write, followed by GAP. A burst start that is out of range is errored on its first beat and ended.
REQ-027 When WBMEM_RANGE_ERR_EN is not defined, address bits above the window are ignored (aliasing) and wb_err_o is constant 0.

Verification
REQ-028 Classic read 0x10, RAM[4] = 32'hDEADBEEF -> wb_ack_o high exactly 1 cycle, on the 2nd cycle after stb, wb_dat_o = 32'hDEADBEEF.
REQ-029 Incrementing burst from 0x40, bte = 00, 8 beats, cti = 111 on the last beat, stb held -> 8 back-to-back acks returning words 0x10..0x17, then ack low.
REQ-030 Wrap-8 burst starting at 0x54 -> beats return word addresses 0x15, 0x16, 0x17, 0x10, 0x11, 0x12, 0x13, 0x14.
REQ-031 Classic write 0x20, sel = 4'b0100, data = 32'h00AB0000 over RAM = 32'h11223344, then read -> 32'h11AB3344.
REQ-032 Burst with stb low for 2 cycles after beat 3 -> no ack in those cycles; beat 4 data equals the word at the next address, and no beat is lost or repeated.
REQ-033 With WBMEM_RANGE_ERR_EN, MEM_AW = 10, read 0x1000 -> wb_err_o for 1 cycle and wb_ack_o stays 0; without the macro the same read returns RAM[0].
